// File: rtl/led_seq_gen.sv
// LED sequence generator: shift-left, shift-right, bounce or fill pattern on a WIDTH-bit bank,
// advanced once every DIV+1 enabled clocks. Bounce mode and DIR exist only with LED_SEQ_BOUNCE_EN.
module led_seq_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             SS,
  input  logic [1:0]       MODE,
  input  logic [DIV_W-1:0] DIV,
  output logic [WIDTH-1:0] LED,
  output logic             STEP,
  output logic             WRAP,
  output logic             DIR
);

  logic [DIV_W-1:0] cnt;
  logic [WIDTH-1:0] nxt_led;
  logic [WIDTH-1:0] shl;
  logic             nxt_wrap;
  logic             step_now;

  assign shl      = LED << 1;
  assign step_now = (cnt >= DIV);

`ifdef LED_SEQ_BOUNCE_EN
  logic nxt_dir;
  logic one_hot;

  assign one_hot = (LED != '0) && ((LED & (LED - WIDTH'(1))) == '0);
`else
  assign DIR = 1'b0;
`endif

  // Next pattern value, evaluated for the MODE sampled at the stepping edge.
  always_comb begin
    nxt_led  = LED;
    nxt_wrap = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
    nxt_dir  = DIR;
`endif
    case (MODE)
      2'b01: begin
        if (LED == '0) begin
          nxt_led = WIDTH'(1) << (WIDTH - 1);
        end else begin
          nxt_led  = LED >> 1;
          nxt_wrap = ((LED >> 1) == '0);
        end
      end
      2'b11: begin
        if (&LED) begin
          nxt_led  = '0;
          nxt_wrap = 1'b1;
        end else begin
          nxt_led = {LED[WIDTH-2:0], 1'b1};
        end
      end
`ifdef LED_SEQ_BOUNCE_EN
      2'b10: begin
        if (!one_hot) begin
          nxt_led = WIDTH'(1);
          nxt_dir = 1'b0;
        end else if (!DIR && LED[WIDTH-1]) begin
          nxt_led = LED >> 1;
          nxt_dir = 1'b1;
        end else if (DIR && LED[0]) begin
          nxt_led  = WIDTH'(2);
          nxt_dir  = 1'b0;
          nxt_wrap = 1'b1;
        end else if (DIR) begin
          nxt_led = LED >> 1;
        end else begin
          nxt_led = shl;
        end
      end
`endif
      default: begin
        // Shift-left; MODE=10 also lands here when bounce is not built in.
        if (LED == '0) begin
          nxt_led = WIDTH'(1);
        end else begin
          nxt_led  = shl;
          nxt_wrap = (shl == '0);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      LED  <= '0;
      STEP <= 1'b0;
      WRAP <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
      DIR  <= 1'b0;
`endif
    end else if (SS) begin
      if (step_now) begin
        cnt  <= '0;
        LED  <= nxt_led;
        STEP <= 1'b1;
        WRAP <= nxt_wrap;
`ifdef LED_SEQ_BOUNCE_EN
        DIR  <= nxt_dir;
`endif
      end else begin
        cnt  <= cnt + DIV_W'(1);
        STEP <= 1'b0;
        WRAP <= 1'b0;
      end
    end else begin
      STEP <= 1'b0;
      WRAP <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_seq_gen.sv
// Bench for led_seq_gen (WIDTH=8): expected {LED,STEP,WRAP,DIR} pushed per driven edge, popped after it.
module tb_led_seq_gen;
  localparam int W  = 8;
  localparam int DW = 16;
  localparam int EW = W + 3;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          ss   = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] div  = '0;
  logic [W-1:0]  led;
  logic          step;
  logic          wrap;
  logic          dir;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  led_seq_gen #(.WIDTH(W), .DIV_W(DW)) dut (
    .Clk(clk), .RST(rst), .SS(ss), .MODE(mode), .DIV(div),
    .LED(led), .STEP(step), .WRAP(wrap), .DIR(dir)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pk(input logic [W-1:0] l, input logic s, input logic w,
                                       input logic d);
    return {l, s, w, d};
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got led=%h step=%b wrap=%b dir=%b, expected led=%h step=%b wrap=%b dir=%b",
               tag, got[EW-1:3], got[2], got[1], got[0], exp[EW-1:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one edge's inputs at the falling edge, compare just after the rising edge.
  task automatic cyc(input string tag, input logic s, input logic [1:0] m, input logic [DW-1:0] d,
                     input logic [EW-1:0] e);
    @(negedge clk);
    ss   = s;
    mode = m;
    div  = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, {led, step, wrap, dir}, exp_q.pop_front());
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    ss  = 1'b0;
    #1;
    check(tag, {led, step, wrap, dir}, pk('0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #3;
    check("power_on_reset", {led, step, wrap, dir}, pk('0, 1'b0, 1'b0, 1'b0));

    // Shift-left, DIV=0
    do_reset("rst_t1");
    for (int e = 1; e <= 10; e++)
      cyc($sformatf("t1_shl_e%0d", e), 1'b1, 2'b00, 16'd0,
          pk((e <= 8) ? (W'(1) << (e - 1)) : ((e == 9) ? W'(0) : W'(1)), 1'b1, e == 9, 1'b0));

    // Shift-right, DIV=2
    do_reset("rst_t2");
    for (int e = 1; e <= 9; e++)
      cyc($sformatf("t2_shr_e%0d", e), 1'b1, 2'b01, 16'd2,
          pk((e < 3) ? W'(0) : (W'(8'h80) >> (e / 3 - 1)), (e % 3) == 0, 1'b0, 1'b0));

    // Bounce, DIV=0
    do_reset("rst_t3");
    for (int e = 1; e <= 17; e++) begin
`ifdef LED_SEQ_BOUNCE_EN
      if (e <= 8)
        cyc($sformatf("t3_bnc_e%0d", e), 1'b1, 2'b10, 16'd0, pk(W'(1) << (e - 1), 1'b1, 1'b0, 1'b0));
      else if (e <= 15)
        cyc($sformatf("t3_bnc_e%0d", e), 1'b1, 2'b10, 16'd0, pk(W'(8'h80) >> (e - 8), 1'b1, 1'b0, 1'b1));
      else
        cyc($sformatf("t3_bnc_e%0d", e), 1'b1, 2'b10, 16'd0,
            pk((e == 16) ? W'(8'h02) : W'(8'h04), 1'b1, e == 16, 1'b0));
`else
      cyc($sformatf("t3_bnc_off_e%0d", e), 1'b1, 2'b10, 16'd0,
          pk((e <= 8) ? (W'(1) << (e - 1)) : ((e == 9) ? W'(0) : (W'(1) << (e - 10))),
             1'b1, e == 9, 1'b0));
`endif
    end

    // Fill, DIV=0
    do_reset("rst_t4");
    for (int e = 1; e <= 10; e++)
      cyc($sformatf("t4_fill_e%0d", e), 1'b1, 2'b11, 16'd0,
          pk((e <= 8) ? ((W'(1) << e) - W'(1)) : ((e == 9) ? W'(0) : W'(1)), 1'b1, e == 9, 1'b0));

    // Freeze with SS=0 mid-count, then async reset between edges
    do_reset("rst_t5");
    for (int e = 1; e <= 18; e++)
      cyc($sformatf("t5_run_e%0d", e), 1'b1, 2'b00, 16'd3,
          pk((e < 4) ? W'(0) : (W'(1) << (e / 4 - 1)), (e % 4) == 0, 1'b0, 1'b0));
    for (int e = 1; e <= 10; e++)
      cyc($sformatf("t5_hold_e%0d", e), 1'b0, 2'b00, 16'd3, pk(W'(8'h08), 1'b0, 1'b0, 1'b0));
    cyc("t5_resume_a", 1'b1, 2'b00, 16'd3, pk(W'(8'h08), 1'b0, 1'b0, 1'b0));
    cyc("t5_resume_b", 1'b1, 2'b00, 16'd3, pk(W'(8'h10), 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_rst", {led, step, wrap, dir}, pk('0, 1'b0, 1'b0, 1'b0));
    ss = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Lowering DIV mid-count steps at the next enabled edge
    do_reset("rst_div");
    cyc("div_e1", 1'b1, 2'b00, 16'd5, pk(W'(0), 1'b0, 1'b0, 1'b0));
    cyc("div_e2", 1'b1, 2'b00, 16'd5, pk(W'(0), 1'b0, 1'b0, 1'b0));
    cyc("div_e3_lowered", 1'b1, 2'b00, 16'd1, pk(W'(1), 1'b1, 1'b0, 1'b0));
    cyc("div_e4", 1'b1, 2'b00, 16'd1, pk(W'(1), 1'b0, 1'b0, 1'b0));
    cyc("div_e5", 1'b1, 2'b00, 16'd1, pk(W'(2), 1'b1, 1'b0, 1'b0));

    // Mode switch: fill 07 -> bounce
    do_reset("rst_t6a");
    cyc("t6a_fill_1", 1'b1, 2'b11, 16'd0, pk(W'(8'h01), 1'b1, 1'b0, 1'b0));
    cyc("t6a_fill_2", 1'b1, 2'b11, 16'd0, pk(W'(8'h03), 1'b1, 1'b0, 1'b0));
    cyc("t6a_fill_3", 1'b1, 2'b11, 16'd0, pk(W'(8'h07), 1'b1, 1'b0, 1'b0));
`ifdef LED_SEQ_BOUNCE_EN
    cyc("t6a_to_bounce", 1'b1, 2'b10, 16'd0, pk(W'(8'h01), 1'b1, 1'b0, 1'b0));
`else
    cyc("t6a_to_mode10", 1'b1, 2'b10, 16'd0, pk(W'(8'h0E), 1'b1, 1'b0, 1'b0));
`endif

    // Mode switch: MODE=10 up to 10, then shift-right
    do_reset("rst_t6b");
    for (int e = 1; e <= 5; e++)
      cyc($sformatf("t6b_m10_e%0d", e), 1'b1, 2'b10, 16'd0, pk(W'(1) << (e - 1), 1'b1, 1'b0, 1'b0));
    cyc("t6b_to_shr", 1'b1, 2'b01, 16'd0, pk(W'(8'h08), 1'b1, 1'b0, 1'b0));

    check("scoreboard_empty", EW'(exp_q.size()), EW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
